ltl_report_collector: RTL

LTL_REPORT_COLLECTOR -- requirements
Module: ltl_report_collector

---
 rtl/ltl_rpt_pkg.sv | 18 +
 rtl/ltl_rpt_fifo.sv | 61 ++++++
 rtl/ltl_report_collector.sv | 105 ++++++++++
 3 files changed

// File: rtl/ltl_rpt_pkg.sv
// Shared constants, report entry type and helpers for the LTL report collector.
package ltl_rpt_pkg;

    localparam int NUM_RPT_DEF = 4;
    localparam int DEPTH_DEF   = 8;
    localparam int IDX_W_DEF   = 32;
    localparam int DROP_CNT_W  = 16;

    typedef struct packed {
        logic [NUM_RPT_DEF-1:0] vec;
        logic [IDX_W_DEF-1:0]   idx;
    } rpt_entry_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ltl_rpt_fifo.sv
// Report FIFO: circular buffer with an occupancy count; a push into a full buffer
// is accepted only when a pop happens in the same cycle.
module ltl_rpt_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           data_i,
    output logic [W-1:0]           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_level == FULL_LVL);
    assign empty_o = (r_level == '0);
    assign w_pop   = pop_i & ~empty_o & ~clear_i;
    assign w_push  = push_i & ~clear_i & (~full_o | w_pop);

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
            else if (w_pop && !w_push) r_level <= r_level - LVL_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the level and pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign level_o = r_level;

endmodule

// File: rtl/ltl_report_collector.sv
// Tags automaton report vectors with the index of the symbol that produced them and queues them.
// Optional macro LTL_REPORT_COALESCE_EN: suppress a report equal to the previously sampled vector.
module ltl_report_collector
    import ltl_rpt_pkg::*;
#(
    parameter int NUM_RPT = NUM_RPT_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   run_i,
    input  logic [NUM_RPT-1:0]     report_i,
    output logic                   rpt_valid_o,
    input  logic                   rpt_ready_i,
    output logic [NUM_RPT-1:0]     rpt_vec_o,
    output logic [IDX_W-1:0]       rpt_idx_o,
    output logic                   overflow_o,
    output logic [15:0]            drop_cnt_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int ENT_W = NUM_RPT + IDX_W;

    logic [IDX_W-1:0]      r_sym_idx;
    logic [IDX_W-1:0]      r_idx_q;
    logic                  r_run_q;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  w_push_req;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_drop;
    logic [ENT_W-1:0]      w_head;

    // The automaton answers one cycle after consuming a symbol, so sample on the delayed run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sym_idx <= '0;
            r_idx_q   <= '0;
            r_run_q   <= 1'b0;
        end else if (clear_i) begin
            r_sym_idx <= '0;
            r_idx_q   <= '0;
            r_run_q   <= 1'b0;
        end else begin
            r_run_q <= run_i;
            r_idx_q <= r_sym_idx;
            if (run_i) r_sym_idx <= r_sym_idx + IDX_W'(1);
        end
    end

`ifdef LTL_REPORT_COALESCE_EN
    logic [NUM_RPT-1:0] r_last_vec;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      r_last_vec <= '0;
        else if (clear_i) r_last_vec <= '0;
        else if (r_run_q) r_last_vec <= report_i;
    end

    assign w_push_req = r_run_q & (|report_i) & (report_i != r_last_vec);
`else
    assign w_push_req = r_run_q & (|report_i);
`endif

    // A full buffer still takes the push when the consumer drains the head in the same cycle.
    assign w_drop = w_push_req & w_full & ~rpt_ready_i & ~clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end

    ltl_rpt_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (w_push_req),
        .pop_i   (rpt_ready_i),
        .data_i  ({report_i, r_idx_q}),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

    assign rpt_valid_o = ~w_empty;
    assign rpt_vec_o   = w_head[ENT_W-1:IDX_W];
    assign rpt_idx_o   = w_head[IDX_W-1:0];
    assign overflow_o  = r_overflow;
    assign drop_cnt_o  = r_drop_cnt;

endmodule
